// File: rtl/pf_stride_monitor.sv
// pf_stride_monitor: per-PC stride detector that turns confident miss
// streams into page-bounded prefetch line addresses behind a small FIFO.
module pf_stride_monitor #(
    parameter int NCH     = 2,
    parameter int LAW     = 33,
    parameter int PCW     = 12,
    parameter int NENT    = 8,
    parameter int CONFW   = 2,
    parameter int CONF_TH = 2,
    parameter int DEG     = 2,
    parameter int PGB     = 6,
    parameter int QDEPTH  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               flush,
    input  logic [NCH-1:0]     mon_valid,
    input  logic [NCH*PCW-1:0] mon_pc,
    input  logic [NCH*LAW-1:0] mon_laddr,
    output logic               pf_valid,
    output logic [LAW-1:0]     pf_laddr,
    input  logic               pf_ready,
    output logic [15:0]        stat_issued,
    output logic [15:0]        stat_dropped
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CXW = CHW + 1;
    localparam int CNW = $clog2(NCH + 1);
    localparam int ENW = (NENT > 1) ? $clog2(NENT) : 1;
    localparam int QW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CTW = QW + 1;
    localparam int PGW = LAW - PGB;
    localparam logic [CONFW-1:0] CMAX = '1;

    typedef enum logic {IDLE, GEN} state_t;

    logic run;
    assign run = enable && !flush;

    logic [CHW-1:0] arb_q;
    logic [CHW-1:0] win;
    logic [CXW-1:0] ix;
    logic [CNW-1:0] nval;
    logic [CNW-1:0] lose;
    logic           found;
    logic           s1_v_q;
    logic [PCW-1:0] s1_pc_q;
    logic [LAW-1:0] s1_la_q;

    always_comb begin
        found = 1'b0;
        win   = '0;
        nval  = '0;
        ix    = '0;
        for (int j = 0; j < NCH; j++) begin
            nval = nval + CNW'(mon_valid[j]);
            ix   = CXW'(arb_q) + CXW'(j);
            if (ix >= CXW'(NCH)) ix = ix - CXW'(NCH);
            if (!found && mon_valid[ix[CHW-1:0]]) begin
                found = 1'b1;
                win   = ix[CHW-1:0];
            end
        end
    end

    assign lose = (run && found) ? nval - CNW'(1) : '0;

    // The pointer only rotates under contention so a lone channel keeps priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arb_q   <= '0;
            s1_v_q  <= 1'b0;
            s1_pc_q <= '0;
            s1_la_q <= '0;
        end else begin
            s1_v_q <= run && found;
            if (run && found) begin
                s1_pc_q <= mon_pc[int'(win)*PCW +: PCW];
                s1_la_q <= mon_laddr[int'(win)*LAW +: LAW];
            end
            if (run && nval > CNW'(1))
                arb_q <= (win == CHW'(NCH - 1)) ? '0 : win + CHW'(1);
        end
    end

    logic [NENT-1:0]  tv_q;
    logic [PCW-1:0]   tpc_q   [NENT];
    logic [LAW-1:0]   tlast_q [NENT];
    logic [LAW-1:0]   tstr_q  [NENT];
    logic [CONFW-1:0] tconf_q [NENT];
    logic [ENW-1:0]   vic_q;
    logic             hit, free, same, upd, trig;
    logic [ENW-1:0]   hidx, fidx, aidx;
    logic [LAW-1:0]   stride;
    logic [CONFW-1:0] nconf;

    always_comb begin
        hit  = 1'b0;
        free = 1'b0;
        hidx = '0;
        fidx = '0;
        for (int e = 0; e < NENT; e++) begin
            if (!hit && tv_q[e] && tpc_q[e] == s1_pc_q) begin
                hit  = 1'b1;
                hidx = ENW'(e);
            end
            if (!free && !tv_q[e]) begin
                free = 1'b1;
                fidx = ENW'(e);
            end
        end
        aidx   = hit ? hidx : (free ? fidx : vic_q);
        stride = s1_la_q - tlast_q[hidx];
        same   = hit && (stride == tstr_q[hidx]) && (stride != '0);
        nconf  = '0;
        if (same)
            nconf = (tconf_q[hidx] == CMAX) ? CMAX : tconf_q[hidx] + CONFW'(1);
        upd  = s1_v_q && run;
        trig = upd && (int'(nconf) >= CONF_TH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tv_q  <= '0;
            vic_q <= '0;
            for (int e = 0; e < NENT; e++) begin
                tpc_q[e]   <= '0;
                tlast_q[e] <= '0;
                tstr_q[e]  <= '0;
                tconf_q[e] <= '0;
            end
        end else if (flush) begin
            tv_q  <= '0;
            vic_q <= '0;
        end else if (upd) begin
            tv_q[aidx]    <= 1'b1;
            tpc_q[aidx]   <= s1_pc_q;
            tlast_q[aidx] <= s1_la_q;
            tstr_q[aidx]  <= hit ? stride : '0;
            tconf_q[aidx] <= nconf;
            if (!hit && !free)
                vic_q <= (vic_q == ENW'(NENT - 1)) ? '0 : vic_q + ENW'(1);
        end
    end

    state_t         st_q;
    logic [PGW-1:0] bpg_q;
    logic [LAW-1:0] str_q;
    logic [LAW-1:0] cand_q;
    logic [2:0]     k_q;
    logic           gen, xcross, dup, cok, push, cdrop;
    logic [LAW-1:0] lp_q;
    logic           lp_v_q;
    logic           full, pop;

    assign gen    = (st_q == GEN) && run;
    assign xcross = cand_q[LAW-1:PGB] != bpg_q;
    assign dup    = lp_v_q && (cand_q == lp_q);
    assign cok    = gen && !xcross && !dup;
    assign push   = cok && !full;
    assign cdrop  = cok && full;

    // cand_q walks base+k*stride by accumulation; a trigger always wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q   <= IDLE;
            bpg_q  <= '0;
            str_q  <= '0;
            cand_q <= '0;
            k_q    <= '0;
        end else if (!run) begin
            st_q <= IDLE;
        end else if (trig) begin
            st_q   <= GEN;
            bpg_q  <= s1_la_q[LAW-1:PGB];
            str_q  <= stride;
            cand_q <= s1_la_q + stride;
            k_q    <= 3'd1;
        end else if (st_q == GEN) begin
            if (xcross || k_q == 3'(DEG)) begin
                st_q <= IDLE;
            end else begin
                k_q    <= k_q + 3'd1;
                cand_q <= cand_q + str_q;
            end
        end
    end

    logic [LAW-1:0] mem_q [QDEPTH];
    logic [QW-1:0]  wr_q, rd_q;
    logic [CTW-1:0] cnt_q;
    logic [15:0]    iss_q, drp_q;
    logic [16:0]    dsum;

    assign full     = cnt_q == CTW'(QDEPTH);
    assign pf_valid = cnt_q != '0;
    assign pf_laddr = mem_q[rd_q];
    assign pop      = pf_valid && pf_ready;
    assign dsum     = {1'b0, drp_q} + 17'(lose) + 17'(cdrop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int q = 0; q < QDEPTH; q++) mem_q[q] <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            lp_q   <= '0;
            lp_v_q <= 1'b0;
            iss_q  <= '0;
            drp_q  <= '0;
        end else begin
            if (pop && iss_q != 16'hFFFF) iss_q <= iss_q + 16'd1;
            drp_q <= dsum[16] ? 16'hFFFF : dsum[15:0];
            if (flush) begin
                wr_q   <= '0;
                rd_q   <= '0;
                cnt_q  <= '0;
                lp_v_q <= 1'b0;
            end else begin
                if (push) begin
                    mem_q[wr_q] <= cand_q;
                    wr_q        <= wr_q + QW'(1);
                    lp_q        <= cand_q;
                    lp_v_q      <= 1'b1;
                end
                if (pop) rd_q <= rd_q + QW'(1);
                cnt_q <= cnt_q + CTW'(push) - CTW'(pop);
            end
        end
    end

    assign stat_issued  = iss_q;
    assign stat_dropped = drp_q;

endmodule

// File: tb/tb_pf_stride_monitor.sv
// Bench for pf_stride_monitor: directed vector table and corner sequences,
// then a randomized run against a queue-based reference model.
module tb_pf_stride_monitor;

    localparam int NCH = 2, LAW = 33, PCW = 12, NENT = 8;
    localparam int CONF_TH = 2, DEG = 2, PGB = 6, QD = 4;

    typedef logic [LAW-1:0] la_t;
    typedef struct {
        logic           v;
        logic [PCW-1:0] pc;
        la_t            la;
        logic           ev;
        la_t            ela;
    } vec_t;

    logic clk = 1'b0;
    logic reset, enable, flush, pf_ready, pf_valid;
    logic [NCH-1:0]     mon_valid;
    logic [NCH*PCW-1:0] mon_pc;
    logic [NCH*LAW-1:0] mon_laddr;
    la_t                pf_laddr;
    logic [15:0]        stat_issued, stat_dropped;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pf_stride_monitor dut (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .mon_valid(mon_valid), .mon_pc(mon_pc), .mon_laddr(mon_laddr),
        .pf_valid(pf_valid), .pf_laddr(pf_laddr), .pf_ready(pf_ready),
        .stat_issued(stat_issued), .stat_dropped(stat_dropped)
    );

    bit             m_tv    [NENT];
    logic [PCW-1:0] m_tpc   [NENT];
    la_t            m_tlast [NENT];
    la_t            m_tstr  [NENT];
    int             m_tconf [NENT];
    int             m_vic, m_arb, m_iss, m_drp;
    bit             m_s1v, m_lpv;
    logic [PCW-1:0] m_s1pc;
    la_t            m_s1la, m_lp;
    la_t            m_gen[$], m_fifo[$], got[$], want[$];

    function automatic int sat16(int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int e = 0; e < NENT; e++) m_tv[e] = 0;
        m_vic = 0; m_arb = 0; m_iss = 0; m_drp = 0;
        m_s1v = 0; m_lpv = 0;
        m_gen.delete(); m_fifo.delete();
    endtask

    task automatic model_step();
        bit  full;
        int  hit, fr, nv, w, ix;
        la_t c, s, la;
        full = (m_fifo.size() == QD);
        if (m_fifo.size() > 0 && pf_ready) begin
            void'(m_fifo.pop_front());
            m_iss = sat16(m_iss + 1);
        end
        if (enable && !flush && m_gen.size() > 0) begin
            c = m_gen.pop_front();
            if (!(m_lpv && c == m_lp)) begin
                if (full) m_drp = sat16(m_drp + 1);
                else begin
                    m_fifo.push_back(c);
                    m_lp = c; m_lpv = 1;
                end
            end
        end
        if (!enable || flush) m_gen.delete();
        if (m_s1v && enable && !flush) begin
            la = m_s1la; hit = -1;
            for (int e = 0; e < NENT; e++)
                if (hit < 0 && m_tv[e] && m_tpc[e] == m_s1pc) hit = e;
            if (hit >= 0) begin
                s = la - m_tlast[hit];
                if (s == m_tstr[hit] && s != 0)
                    m_tconf[hit] = (m_tconf[hit] >= 3) ? 3 : m_tconf[hit] + 1;
                else begin
                    m_tstr[hit] = s; m_tconf[hit] = 0;
                end
                m_tlast[hit] = la;
                if (m_tconf[hit] >= CONF_TH) begin
                    m_gen.delete();
                    for (int k = 1; k <= DEG; k++) begin
                        c = la + la_t'(k) * s;
                        if (c[LAW-1:PGB] != la[LAW-1:PGB]) break;
                        m_gen.push_back(c);
                    end
                end
            end else begin
                fr = -1;
                for (int e = 0; e < NENT; e++)
                    if (fr < 0 && !m_tv[e]) fr = e;
                if (fr < 0) begin
                    fr = m_vic; m_vic = (m_vic + 1) % NENT;
                end
                m_tv[fr] = 1; m_tpc[fr] = m_s1pc; m_tlast[fr] = la;
                m_tstr[fr] = 0; m_tconf[fr] = 0;
            end
        end
        m_s1v = 0;
        if (enable && !flush) begin
            nv = 0; w = -1;
            for (int j = 0; j < NCH; j++) begin
                ix = (m_arb + j) % NCH;
                if (mon_valid[j]) nv++;
                if (w < 0 && mon_valid[ix]) w = ix;
            end
            if (w >= 0) begin
                m_s1v = 1;
                m_s1pc = mon_pc[w*PCW +: PCW];
                m_s1la = mon_laddr[w*LAW +: LAW];
                m_drp = sat16(m_drp + nv - 1);
                if (nv > 1) m_arb = (w + 1) % NCH;
            end
        end
        if (flush) begin
            for (int e = 0; e < NENT; e++) m_tv[e] = 0;
            m_vic = 0; m_lpv = 0;
            m_fifo.delete(); m_gen.delete();
        end
    endtask

    task automatic chk_model();
        chk("m_valid", pf_valid, m_fifo.size() > 0);
        if (m_fifo.size() > 0) chk("m_laddr", pf_laddr, m_fifo[0]);
        chk("m_issued", stat_issued, m_iss);
        chk("m_dropped", stat_dropped, m_drp);
    endtask

    task automatic tick();
        chk_model();
        if (pf_valid && pf_ready) got.push_back(pf_laddr);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; enable = 1'b1; flush = 1'b0; pf_ready = 1'b1;
        mon_valid = '0; mon_pc = '0; mon_laddr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        got.delete();
    endtask

    task automatic idle(int n);
        mon_valid = '0;
        repeat (n) tick();
    endtask

    task automatic train(logic [PCW-1:0] pc, la_t base, la_t st, int n, int ch);
        for (int i = 0; i < n; i++) begin
            mon_valid = '0; mon_valid[ch] = 1'b1;
            mon_pc = '0; mon_pc[ch*PCW +: PCW] = pc;
            mon_laddr = '0; mon_laddr[ch*LAW +: LAW] = base + la_t'(i) * st;
            tick();
        end
        mon_valid = '0;
    endtask

    task automatic chk_got(string nm);
        chk({nm, "_n"}, got.size(), want.size());
        for (int i = 0; i < want.size(); i++)
            chk(nm, (i < got.size()) ? got[i] : 'x, want[i]);
    endtask

    initial begin
        vec_t tv[9];
        la_t  gla[12], gst[12], stab[6];
        int   p;
        tv[0] = '{1, 12'h10, 33'h100, 0, 0};
        tv[1] = '{1, 12'h10, 33'h102, 0, 0};
        tv[2] = '{1, 12'h10, 33'h104, 0, 0};
        tv[3] = '{1, 12'h10, 33'h106, 0, 0};
        tv[4] = '{0, 12'h0, 33'h0, 0, 0};
        tv[5] = '{0, 12'h0, 33'h0, 0, 0};
        tv[6] = '{0, 12'h0, 33'h0, 1, 33'h108};
        tv[7] = '{0, 12'h0, 33'h0, 1, 33'h10A};
        tv[8] = '{0, 12'h0, 33'h0, 0, 0};

        do_reset();
        chk("rst_valid", pf_valid, 0);
        chk("rst_laddr", pf_laddr, 0);
        chk("rst_issued", stat_issued, 0);
        chk("rst_dropped", stat_dropped, 0);

        for (int i = 0; i < 9; i++) begin
            mon_valid = {1'b0, tv[i].v};
            mon_pc    = {12'h0, tv[i].pc};
            mon_laddr = {33'h0, tv[i].la};
            chk("vec_valid", pf_valid, tv[i].ev);
            if (tv[i].ev) chk("vec_laddr", pf_laddr, tv[i].ela);
            tick();
        end
        chk("stride_issued", stat_issued, 2);

        do_reset();
        train(12'h20, 33'h13B, 33'h1, 4, 0);
        idle(8);
        want.delete(); want.push_back(33'h13F);
        chk_got("page");
        chk("page_dropped", stat_dropped, 0);

        do_reset();
        train(12'h40, 33'h4, '1, 4, 1);
        idle(8);
        want.delete(); want.push_back(33'h0);
        chk_got("wrap");

        do_reset();
        for (int c = 0; c < 8; c++) begin
            mon_valid = 2'b11;
            mon_pc = {12'h32, 12'h31};
            mon_laddr[LAW-1:0] = (c % 2 == 0) ? la_t'(33'h200 + c) : la_t'(33'h9000 + 53 * c);
            mon_laddr[2*LAW-1:LAW] = (c % 2 == 1) ? la_t'(33'h400 + c / 2) : la_t'(33'hA000 + 81 * c);
            tick();
        end
        idle(8);
        chk("arb_dropped", stat_dropped, 8);
        want.delete();
        want.push_back(33'h208); want.push_back(33'h404); want.push_back(33'h405);
        chk_got("arb_preempt");

        do_reset();
        pf_ready = 1'b0;
        train(12'h51, 33'h1000, 33'h1, 4, 0); idle(6);
        train(12'h52, 33'h2000, 33'h1, 4, 1); idle(6);
        train(12'h53, 33'h3000, 33'h1, 4, 0); idle(6);
        chk("full_dropped", stat_dropped, 2);
        chk("full_valid", pf_valid, 1);
        chk("full_hold", pf_laddr, 33'h1004);
        pf_ready = 1'b1;
        idle(6);
        want.delete();
        want.push_back(33'h1004); want.push_back(33'h1005);
        want.push_back(33'h2004); want.push_back(33'h2005);
        chk_got("full_drain");
        chk("full_issued", stat_issued, 4);

        pf_ready = 1'b0;
        train(12'h61, 33'h700, 33'h1, 4, 0);
        idle(2);
        chk("midgen_pre", pf_valid, 1);
        #2 reset = 1'b0;
        #1;
        chk("midgen_valid", pf_valid, 0);
        chk("midgen_issued", stat_issued, 0);
        chk("midgen_dropped", stat_dropped, 0);
        chk("midgen_laddr", pf_laddr, 0);

        do_reset();
        stab[0] = 33'h1; stab[1] = 33'h2; stab[2] = 33'h3;
        stab[3] = '1; stab[4] = 33'h1FFFFFFFE; stab[5] = 33'h0;
        for (int i = 0; i < 12; i++) begin
            gla[i] = la_t'(i) * 33'h1000 + la_t'($urandom_range(0, 255));
            gst[i] = stab[$urandom_range(0, 5)];
        end
        for (int c = 0; c < 4000; c++) begin
            enable   = $urandom_range(0, 99) >= 3;
            flush    = $urandom_range(0, 299) == 0;
            pf_ready = $urandom_range(0, 99) < 60;
            for (int ch = 0; ch < NCH; ch++) begin
                mon_valid[ch] = $urandom_range(0, 99) < 45;
                p = int'($urandom_range(0, 11));
                mon_pc[ch*PCW +: PCW] = PCW'(p + 1);
                mon_laddr[ch*LAW +: LAW] = gla[p];
                gla[p] = gla[p] + gst[p];
                if ($urandom_range(0, 15) == 0) gst[p] = stab[$urandom_range(0, 5)];
                if ($urandom_range(0, 63) == 0) gla[p] = {1'b0, $urandom};
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
